wb_stage_burst: RTL and testbench
=================================

Name: wb_stage_burst

Overview:
- Registered, handshaked successor to the combinational write-back mux.
- Selects the ALU or memory result for scalar and vector ops and drives the scalar register-file write port.
- Streams vector results into a narrower vector register-file write port as LANES_PER_BEAT-wide beats, with per-lane write masking.
- Sits between the MEM stage and the register files; provides backpressure to MEM through in_ready.

Parameters:
- WIDTH, 16, bits per element.
- VECTOR_LENGTH, 16, elements per vector.
- LANES_PER_BEAT, 4, elements written per vector write cycle. VECTOR_LENGTH % LANES_PER_BEAT != 0 is an elaboration error.
- REG_ADDR_W, 4, register address width.
- Derived: BEATS = VECTOR_LENGTH/LANES_PER_BEAT; BEAT_W = max(1, clog2(BEATS)).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  op presented.
- in_ready  out  1  stage can accept.
- flush  in  1  synchronous abort.
- vecop  in  1  1 = vector op, 0 = scalar op.
- aluop  in  1  1 = ALU result, 0 = memory result.
- register_Write  in  REG_ADDR_W  destination register.
- lane_mask  in  VECTOR_LENGTH  per-element write enable (vector only).
- mem_out_scalar / alu_out_scalar  in  WIDTH  scalar sources.
- mem_out_vector / alu_out_vector  in  WIDTH x VECTOR_LENGTH  vector sources.
- sc_we  out  1  scalar write strobe.
- sc_addr  out  REG_ADDR_W  scalar write address.
- sc_data  out  WIDTH  scalar write data.
- vec_we  out  1  vector beat strobe.
- vec_addr  out  REG_ADDR_W  vector write address.
- vec_beat  out  BEAT_W  beat index; elements beat*LANES_PER_BEAT upward.
- vec_data  out  WIDTH x LANES_PER_BEAT  beat data.
- vec_lane_we  out  LANES_PER_BEAT  lane enables for the beat.
- busy  out  1  burst in progress.

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0; the capture buffer is not reset.
- Acceptance: accept = in_valid & in_ready & !flush. in_ready = (IDLE) | (BURST & beat is the last beat).
- Source mux: aluop=1 selects alu_*, aluop=0 selects mem_*. Both the scalar and the vector paths use it.

Scalar op accepted in cycle N:
- Cycle N+1: sc_we=1, sc_addr/sc_data registered.
- sc_we is a one-cycle pulse.
- State stays IDLE, so back-to-back scalar ops run at full rate.

Vector op accepted in cycle N:
- The selected vector and lane_mask are captured in cycle N.
- State goes to BURST.
- Beat k is driven in cycle N+1+k, k = 0..BEATS-1, with vec_we=1, vec_beat=k, vec_data = the element slice, vec_lane_we = the mask slice.
- busy=1 throughout BURST.
- In the last-beat cycle in_ready=1. If an op is accepted there, its first output appears the next cycle (no bubble). Otherwise return to IDLE.
- An all-zero mask slice is still emitted, with vec_lane_we=0.

General rules:
- sc_we and vec_we are never both 1 in the same cycle.
- flush: has priority over in_valid. Next cycle sc_we=0 and vec_we=0, state IDLE, remaining beats dropped; beats already written are not undone.
- rst_n asserted mid-burst: immediate return to IDLE, outputs 0.
- in_valid low: no writes are generated; held operands are ignored.

Optional Feature:
- Macro: WB_SKIP_EMPTY_BEATS_EN.
- Defined:
  - Beats whose mask slice is all-zero are not emitted; the beat counter jumps to the next non-zero slice.
  - "Last beat" means the last non-zero slice.
  - A vector op with lane_mask==0 produces no writes and stays IDLE; in_ready stays 1.
- Undefined: all BEATS beats are always emitted, as described above.

Decomposition:
- Shared package wb_pkg holds:
  - the state enum (IDLE, BURST);
  - the function computing BEAT_W;
  - the function returning the next non-zero beat index, used only under the feature.
- One sub-module, wb_beat_sequencer: beat counter, last-beat detect, skip logic.
- The top holds the muxes, capture buffer and output registers.

Test Plan:
- Scalar ALU: aluop=1, alu_out_scalar=16'h1234, register_Write=3, accepted cycle 10 -> cycle 11: sc_we=1, sc_addr=3, sc_data=16'h1234; cycle 12: sc_we=0.
- Vector memory, full mask: aluop=0, mem_out_vector[i]=i, lane_mask=16'hFFFF, dest 5 -> 4 consecutive beats 0..3 with vec_data = {4k+3..4k}, vec_lane_we=4'hF; in_ready low on beats 0-2, high on beat 3.
- Back-to-back: vector op followed by a scalar op presented continuously -> scalar op accepted on beat 3; sc_we appears the cycle after beat 3; no idle cycle between.
- Partial mask 16'h00F0: without the feature -> 4 beats, vec_lane_we = 0,F,0,0. With WB_SKIP_EMPTY_BEATS_EN -> one beat, vec_beat=1, vec_lane_we=F; in_ready high in that cycle.
- Flush after beat 1 -> beats 2 and 3 never appear; busy=0 and in_ready=1 the next cycle.
- Reset mid-burst: rst_n low during beat 2 -> vec_we, busy, sc_we go 0 immediately without waiting for a clock edge; after release, the first accepted op behaves normally.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and helpers for the burst write-back stage.
// Optional beat skipping: WB_SKIP_EMPTY_BEATS_EN.
package wb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int MAX_BEATS = 64;

    function automatic int beat_w(input int beats);
        if (beats > 1) return $clog2(beats);
        return 1;
    endfunction

    // First beat index >= from with a non-empty mask slice;
    // 8'hFF when no such beat exists.
    function automatic logic [7:0] next_nz(
        input logic [MAX_BEATS-1:0] nz,
        input logic [7:0]           from
    );
        logic [7:0] r;
        r = 8'hFF;
        for (int i = MAX_BEATS - 1; i >= 0; i--) begin
            if (8'(i) >= from && nz[i]) r = 8'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_stage_burst_beat_sequencer.sv
// Beat counter, last-beat detect and empty-slice skipping.
// Skipping is enabled by WB_SKIP_EMPTY_BEATS_EN.
module wb_beat_sequencer
    import wb_pkg::*;
#(
    parameter int VL     = 16,
    parameter int LANES  = 4,
    parameter int BEATS  = VL / LANES,
    parameter int BEAT_W = beat_w(BEATS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [VL-1:0]     in_mask,
    input  logic [VL-1:0]     buf_mask,
    output logic [BEAT_W-1:0] first_beat,
    output logic              has_beats,
    output logic [BEAT_W-1:0] next_beat,
    output logic              last
);

    logic [BEAT_W-1:0] cnt;

`ifdef WB_SKIP_EMPTY_BEATS_EN
    logic [MAX_BEATS-1:0] in_nz;
    logic [MAX_BEATS-1:0] buf_nz;
    logic [7:0]           f8;
    logic [7:0]           n8;

    // Find the first and following non-empty slices.
    always_comb begin
        in_nz  = '0;
        buf_nz = '0;
        for (int b = 0; b < BEATS; b++) begin
            in_nz[b]  = |in_mask[b*LANES +: LANES];
            buf_nz[b] = |buf_mask[b*LANES +: LANES];
        end
        f8         = next_nz(in_nz, 8'd0);
        n8         = next_nz(buf_nz, 8'(cnt) + 8'd1);
        first_beat = f8[BEAT_W-1:0];
        has_beats  = (f8 != 8'hFF);
        next_beat  = n8[BEAT_W-1:0];
        last       = (n8 == 8'hFF);
    end
`else
    wire unused_masks = ^{in_mask, buf_mask};

    assign first_beat = '0;
    assign has_beats  = 1'b1;
    assign next_beat  = cnt + BEAT_W'(1);
    assign last       = (cnt == BEAT_W'(BEATS - 1));
`endif

    // Track the beat currently on the output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= first_beat;
        end else if (step) begin
            cnt <= next_beat;
        end
    end

endmodule

// File: rtl/wb_stage_burst.sv
// Registered write-back stage: scalar writes and vector bursts.
// Optional empty-beat skipping: WB_SKIP_EMPTY_BEATS_EN.
module wb_stage_burst
    import wb_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int VECTOR_LENGTH  = 16,
    parameter int LANES_PER_BEAT = 4,
    parameter int REG_ADDR_W     = 4,
    localparam int BEATS  = VECTOR_LENGTH / LANES_PER_BEAT,
    localparam int BEAT_W = beat_w(BEATS),
    localparam int VW     = WIDTH * VECTOR_LENGTH,
    localparam int BW     = WIDTH * LANES_PER_BEAT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      flush,
    input  logic                      vecop,
    input  logic                      aluop,
    input  logic [REG_ADDR_W-1:0]     register_Write,
    input  logic [VECTOR_LENGTH-1:0]  lane_mask,
    input  logic [WIDTH-1:0]          mem_out_scalar,
    input  logic [WIDTH-1:0]          alu_out_scalar,
    input  logic [VW-1:0]             mem_out_vector,
    input  logic [VW-1:0]             alu_out_vector,
    output logic                      sc_we,
    output logic [REG_ADDR_W-1:0]     sc_addr,
    output logic [WIDTH-1:0]          sc_data,
    output logic                      vec_we,
    output logic [REG_ADDR_W-1:0]     vec_addr,
    output logic [BEAT_W-1:0]         vec_beat,
    output logic [BW-1:0]             vec_data,
    output logic [LANES_PER_BEAT-1:0] vec_lane_we,
    output logic                      busy
);

    if (VECTOR_LENGTH % LANES_PER_BEAT != 0) begin : g_bad_lanes
        $error("VECTOR_LENGTH must be a multiple of LANES_PER_BEAT");
    end
    if (BEATS > MAX_BEATS) begin : g_bad_beats
        $error("too many beats per vector");
    end

    state_t state_q;
    state_t state_d;

    logic                      accept;
    logic                      ld_sc;
    logic                      ld_vec;
    logic                      step;
    logic [BEAT_W-1:0]         first_beat;
    logic                      has_beats;
    logic [BEAT_W-1:0]         next_beat;
    logic                      last;
    logic [WIDTH-1:0]          sel_sc;
    logic [VW-1:0]             sel_vec;
    logic [VW-1:0]             buf_vec;
    logic [VECTOR_LENGTH-1:0]  buf_mask;
    logic [BW-1:0]             new_data;
    logic [LANES_PER_BEAT-1:0] new_lanes;
    logic [BW-1:0]             buf_data;
    logic [LANES_PER_BEAT-1:0] buf_lanes;

    assign busy     = (state_q == BURST);
    assign in_ready = (state_q == IDLE) || last;
    assign accept   = in_valid & in_ready & ~flush;
    assign sel_sc   = aluop ? alu_out_scalar : mem_out_scalar;
    assign sel_vec  = aluop ? alu_out_vector : mem_out_vector;

    wb_beat_sequencer #(
        .VL     (VECTOR_LENGTH),
        .LANES  (LANES_PER_BEAT),
        .BEATS  (BEATS),
        .BEAT_W (BEAT_W)
    ) u_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (ld_vec),
        .step       (step),
        .in_mask    (lane_mask),
        .buf_mask   (buf_mask),
        .first_beat (first_beat),
        .has_beats  (has_beats),
        .next_beat  (next_beat),
        .last       (last)
    );

    // Slice the incoming vector and the captured one for the next beat.
    always_comb begin
        new_data  = sel_vec[int'(first_beat)*BW +: BW];
        new_lanes = lane_mask[int'(first_beat)*LANES_PER_BEAT +: LANES_PER_BEAT];
        buf_data  = buf_vec[int'(next_beat)*BW +: BW];
        buf_lanes = buf_mask[int'(next_beat)*LANES_PER_BEAT +: LANES_PER_BEAT];
    end

    // Next state and load decisions; flush beats everything.
    always_comb begin
        state_d = state_q;
        ld_sc   = 1'b0;
        ld_vec  = 1'b0;
        step    = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else if (busy && !last) begin
            step = 1'b1;
        end else if (accept) begin
            if (vecop) begin
                ld_vec  = has_beats;
                state_d = has_beats ? BURST : IDLE;
            end else begin
                ld_sc   = 1'b1;
                state_d = IDLE;
            end
        end else begin
            state_d = IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Capture buffer holds the vector for the rest of the burst.
    always_ff @(posedge clk) begin
        if (ld_vec) begin
            buf_vec  <= sel_vec;
            buf_mask <= lane_mask;
        end
    end

    // Register-file write port registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc_we       <= 1'b0;
            sc_addr     <= '0;
            sc_data     <= '0;
            vec_we      <= 1'b0;
            vec_addr    <= '0;
            vec_beat    <= '0;
            vec_data    <= '0;
            vec_lane_we <= '0;
        end else begin
            sc_we  <= ld_sc;
            vec_we <= ld_vec | step;
            if (ld_sc) begin
                sc_addr <= register_Write;
                sc_data <= sel_sc;
            end
            if (ld_vec) begin
                vec_addr    <= register_Write;
                vec_beat    <= first_beat;
                vec_data    <= new_data;
                vec_lane_we <= new_lanes;
            end else if (step) begin
                vec_beat    <= next_beat;
                vec_data    <= buf_data;
                vec_lane_we <= buf_lanes;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage_burst.sv
// Self-checking bench for wb_stage_burst.
// Follows WB_SKIP_EMPTY_BEATS_EN when defined.
module tb_wb_stage_burst;

    localparam int W     = 16;
    localparam int VL    = 16;
    localparam int L     = 4;
    localparam int BEATS = 4;

`ifdef WB_SKIP_EMPTY_BEATS_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          flush = 1'b0;
    logic          vecop = 1'b0;
    logic          aluop = 1'b0;
    logic [3:0]    register_Write = '0;
    logic [VL-1:0] lane_mask = '0;
    logic [W-1:0]  mem_s = '0;
    logic [W-1:0]  alu_s = '0;
    logic [255:0]  mem_v = '0;
    logic [255:0]  alu_v = '0;
    logic          sc_we;
    logic [3:0]    sc_addr;
    logic [W-1:0]  sc_data;
    logic          vec_we;
    logic [3:0]    vec_addr;
    logic [1:0]    vec_beat;
    logic [63:0]   vec_data;
    logic [3:0]    vec_lane_we;
    logic          busy;

    wb_stage_burst dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .flush          (flush),
        .vecop          (vecop),
        .aluop          (aluop),
        .register_Write (register_Write),
        .lane_mask      (lane_mask),
        .mem_out_scalar (mem_s),
        .alu_out_scalar (alu_s),
        .mem_out_vector (mem_v),
        .alu_out_vector (alu_v),
        .sc_we          (sc_we),
        .sc_addr        (sc_addr),
        .sc_data        (sc_data),
        .vec_we         (vec_we),
        .vec_addr       (vec_addr),
        .vec_beat       (vec_beat),
        .vec_data       (vec_data),
        .vec_lane_we    (vec_lane_we),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        vecop;
        logic        aluop;
        logic [3:0]  rd;
        logic [15:0] mask;
        logic [15:0] seed;
        logic [15:0] sc_exp;
        int          nwr;
    } vec_t;

    typedef struct {
        logic        vk;
        logic [3:0]  addr;
        logic [1:0]  beat;
        logic [63:0] data;
        logic [3:0]  lanes;
        int          at;
        logic        last;
    } exp_t;

    exp_t q[$];
    exp_t e;
    vec_t tbl[9];
    int   nvec = 0;
    int   nmis = 0;
    int   nwrites = 0;
    int   total = 0;

    function automatic void chk(input string nm,
                                input logic [63:0] act,
                                input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endfunction

    function automatic logic [15:0] elem(input logic a,
                                         input logic [15:0] s,
                                         input int i);
        if (a) return s + 16'(i * 257);
        return s + 16'(i);
    endfunction

    task automatic set_op(input vec_t o);
        vecop          = o.vecop;
        aluop          = o.aluop;
        register_Write = o.rd;
        lane_mask      = o.mask;
        alu_s          = o.seed;
        mem_s          = ~o.seed;
        for (int i = 0; i < VL; i++) begin
            alu_v[i*W +: W] = elem(1'b1, o.seed, i);
            mem_v[i*W +: W] = elem(1'b0, o.seed, i);
        end
    endtask

    task automatic push_expect(input vec_t o);
        exp_t x;
        int   bl[$];
        if (!o.vecop) begin
            x.vk    = 1'b0;
            x.addr  = o.rd;
            x.beat  = 2'd0;
            x.data  = 64'(o.sc_exp);
            x.lanes = 4'd0;
            x.at    = cyc + 1;
            x.last  = 1'b1;
            q.push_back(x);
            return;
        end
        for (int b = 0; b < BEATS; b++) begin
            if (!SKIP || o.mask[b*L +: L] != 4'd0) bl.push_back(b);
        end
        foreach (bl[k]) begin
            x.vk    = 1'b1;
            x.addr  = o.rd;
            x.beat  = 2'(bl[k]);
            x.lanes = o.mask[bl[k]*L +: L];
            for (int j = 0; j < L; j++)
                x.data[j*W +: W] = elem(o.aluop, o.seed, bl[k]*L + j);
            x.at    = cyc + 1 + k;
            x.last  = (k == bl.size() - 1);
            q.push_back(x);
        end
    endtask

    task automatic drive_op(input vec_t o);
        bit done;
        done = 1'b0;
        set_op(o);
        in_valid = 1'b1;
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge clk);
            #1;
            if (in_ready && !flush) begin
                push_expect(o);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("accept_timeout", 64'(in_ready), 64'd1);
    endtask

    // Scoreboard: every write strobe pops one expected write.
    always @(negedge clk) begin
        if (rst_n && (sc_we || vec_we)) begin
            nwrites++;
            chk("we_exclusive", 64'(sc_we & vec_we), 64'd0);
            if (q.size() == 0) begin
                chk("unexpected_write", 64'({sc_we, vec_we}), 64'd0);
            end else begin
                e = q.pop_front();
                chk("write_cycle", 64'(cyc), 64'(e.at));
                if (!e.vk) begin
                    chk("sc_we", 64'(sc_we), 64'd1);
                    chk("sc_addr", 64'(sc_addr), 64'(e.addr));
                    chk("sc_data", 64'(sc_data), e.data);
                end else begin
                    chk("vec_we", 64'(vec_we), 64'd1);
                    chk("vec_addr", 64'(vec_addr), 64'(e.addr));
                    chk("vec_beat", 64'(vec_beat), 64'(e.beat));
                    chk("vec_data", vec_data, e.data);
                    chk("vec_lane_we", 64'(vec_lane_we), 64'(e.lanes));
                    chk("burst_in_ready", 64'(in_ready), 64'(e.last));
                    chk("burst_busy", 64'(busy), 64'd1);
                end
            end
        end
    end

    vec_t fo;

    initial begin
        tbl[0] = '{1'b0, 1'b1, 4'd3,  16'h0000, 16'h1234, 16'h1234, 1};
        tbl[1] = '{1'b1, 1'b0, 4'd5,  16'hFFFF, 16'h0000, 16'h0000, 4};
        tbl[2] = '{1'b0, 1'b0, 4'd7,  16'h0000, 16'h00FF, 16'hFF00, 1};
        tbl[3] = '{1'b1, 1'b1, 4'd9,  16'h00F0, 16'h0100, 16'h0000,
                   SKIP ? 1 : 4};
        tbl[4] = '{1'b0, 1'b1, 4'd15, 16'h0000, 16'hABCD, 16'hABCD, 1};
        tbl[5] = '{1'b0, 1'b1, 4'd0,  16'h0000, 16'h0000, 16'h0000, 1};
        tbl[6] = '{1'b1, 1'b1, 4'd2,  16'h8001, 16'h2000, 16'h0000,
                   SKIP ? 2 : 4};
        tbl[7] = '{1'b1, 1'b0, 4'd1,  16'h0000, 16'h0300, 16'h0000,
                   SKIP ? 0 : 4};
        tbl[8] = '{1'b0, 1'b0, 4'd4,  16'h0000, 16'h5A5A, 16'hA5A5, 1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_sc_we", 64'(sc_we), 64'd0);
        chk("rst_vec_we", 64'(vec_we), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_vec_data", vec_data, 64'd0);
        chk("rst_sc_data", 64'(sc_data), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        nwrites = 0;
        total   = 0;
        for (int i = 0; i < 9; i++) begin
            total += tbl[i].nwr;
            drive_op(tbl[i]);
        end
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("table_writes", 64'(nwrites), 64'(total));
        chk("table_drained", 64'(q.size()), 64'd0);

        // Held operands with in_valid low must not write.
        lane_mask = 16'hFFFF;
        vecop     = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Flush has priority over a valid op while idle.
        fo = '{1'b0, 1'b1, 4'd6, 16'h0000, 16'h7777, 16'h7777, 1};
        set_op(fo);
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        #1;
        chk("flush_idle_sc_we", 64'(sc_we), 64'd0);
        @(posedge clk);
        #1;

        // Flush during beat 1 drops beats 2 and 3.
        fo = '{1'b1, 1'b0, 4'd8, 16'hFFFF, 16'h0400, 16'h0000, 4};
        drive_op(fo);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        #1;
        chk("flush_pending", 64'(q.size()), 64'd2);
        q.delete();
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        #1;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_vec_we", 64'(vec_we), 64'd0);
        repeat (4) @(posedge clk);
        #1;

        // Asynchronous reset during beat 2.
        fo = '{1'b1, 1'b1, 4'd10, 16'hFFFF, 16'h0500, 16'h0000, 4};
        drive_op(fo);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        chk("pre_rst_vec_we", 64'(vec_we), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_vec_we", 64'(vec_we), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_sc_we", 64'(sc_we), 64'd0);
        chk("arst_vec_data", vec_data, 64'd0);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        fo = '{1'b0, 1'b0, 4'd11, 16'h0000, 16'h0F0F, 16'hF0F0, 1};
        drive_op(fo);
        fo = '{1'b1, 1'b0, 4'd12, 16'h0F00, 16'h0600, 16'h0000, 4};
        drive_op(fo);
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        chk("final_drained", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
